// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO controller: register offsets and address decode.
package gpio_pkg;
  localparam int GPIO_MAX_WIDTH = 32;

  localparam logic [7:0] OFS_DIR        = 8'h00;
  localparam logic [7:0] OFS_OUT        = 8'h04;
  localparam logic [7:0] OFS_IN         = 8'h08;
  localparam logic [7:0] OFS_IRQ_EN     = 8'h0C;
  localparam logic [7:0] OFS_IRQ_RISE   = 8'h10;
  localparam logic [7:0] OFS_IRQ_FALL   = 8'h14;
  localparam logic [7:0] OFS_IRQ_STATUS = 8'h18;
  localparam logic [7:0] OFS_OUT_SET    = 8'h1C;
  localparam logic [7:0] OFS_OUT_CLR    = 8'h20;

  typedef enum logic [3:0] {
    DEC_DIR, DEC_OUT, DEC_IN, DEC_IRQ_EN, DEC_IRQ_RISE, DEC_IRQ_FALL,
    DEC_IRQ_STATUS, DEC_OUT_SET, DEC_OUT_CLR, DEC_NONE
  } gpio_dec_e;

  // Word-aligned decode; the two byte-lane bits never select a register.
  function automatic gpio_dec_e gpio_decode(input logic [7:0] addr);
    gpio_dec_e d;
    case ({addr[7:2], 2'b00})
      OFS_DIR:        d = DEC_DIR;
      OFS_OUT:        d = DEC_OUT;
      OFS_IN:         d = DEC_IN;
      OFS_IRQ_EN:     d = DEC_IRQ_EN;
      OFS_IRQ_RISE:   d = DEC_IRQ_RISE;
      OFS_IRQ_FALL:   d = DEC_IRQ_FALL;
      OFS_IRQ_STATUS: d = DEC_IRQ_STATUS;
      OFS_OUT_SET:    d = DEC_OUT_SET;
      OFS_OUT_CLR:    d = DEC_OUT_CLR;
      default:        d = DEC_NONE;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser with edge detection, gated by a post-reset arming counter.
module gpio_sync_edge #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             pclk,
  input  logic             n_p_reset,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_evt,
  output logic [WIDTH-1:0] fall_evt
);
  localparam int ARM_CNT = SYNC_STAGES + 1;
  localparam int CW      = $clog2(ARM_CNT + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [CW-1:0]                     arm_cnt;
  logic                              armed;

  assign armed    = (arm_cnt == CW'(ARM_CNT));
  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      sync_q  <= '0;
      prev_q  <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
      prev_q <= sync_out;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  // Masked until the chain has flushed its reset zeros, so a pin held high is not a rise.
  assign rise_evt = {WIDTH{armed}} &  sync_out & ~prev_q;
  assign fall_evt = {WIDTH{armed}} & ~sync_out &  prev_q;
endmodule

// File: rtl/gpio_ctrl_v2.sv
// APB-programmable GPIO: direction/output registers, synchronised inputs, edge interrupts.
module gpio_ctrl_v2
  import gpio_pkg::*;
#(
  parameter int GPIO_DATA_WIDTH = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                       pclk,
  input  logic                       n_p_reset,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [7:0]                 paddr,
  input  logic [31:0]                pwdata,
  output logic [31:0]                prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [GPIO_DATA_WIDTH-1:0] n_gpio_pin_oe,
  output logic [GPIO_DATA_WIDTH-1:0] gpio_pin_out,
  input  logic [GPIO_DATA_WIDTH-1:0] gpio_pin_in,
  output logic                       gpio_irq
);
  localparam int W = GPIO_DATA_WIDTH;

  gpio_dec_e      dec;
  logic           wr_en;
  logic [W-1:0]   wd, rd_w, w1c, evt;
  logic [W-1:0]   dir_q, out_q, irq_en_q, rise_q, fall_q, status_q;
  logic [W-1:0]   sync_in, rise_evt, fall_evt;
  logic           irq_q;
  logic           unused_ok;

  assign dec       = gpio_decode(paddr);
  assign wr_en     = psel & penable & pwrite & (dec != DEC_NONE);
  assign wd        = pwdata[W-1:0];
  assign unused_ok = ^{paddr[1:0], pwdata};

  gpio_sync_edge #(.WIDTH(W), .SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .pclk      (pclk),
    .n_p_reset (n_p_reset),
    .pin_in    (gpio_pin_in),
    .sync_out  (sync_in),
    .rise_evt  (rise_evt),
    .fall_evt  (fall_evt)
  );

  assign evt = (rise_evt & rise_q) | (fall_evt & fall_q);
  assign w1c = (wr_en && dec == DEC_IRQ_STATUS) ? wd : '0;

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      dir_q    <= '0;
      out_q    <= '0;
      irq_en_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        case (dec)
          DEC_DIR:      dir_q    <= wd;
          DEC_OUT:      out_q    <= wd;
          DEC_IRQ_EN:   irq_en_q <= wd;
          DEC_IRQ_RISE: rise_q   <= wd;
          DEC_IRQ_FALL: fall_q   <= wd;
          DEC_OUT_SET:  out_q    <= out_q | wd;
          DEC_OUT_CLR:  out_q    <= out_q & ~wd;
          default: ;
        endcase
      end
      // New events are OR'd in after the clear so a coincident event survives the W1C.
      status_q <= (status_q & ~w1c) | evt;
      irq_q    <= |(status_q & irq_en_q);
    end
  end

  always_comb begin
    rd_w = '0;
    case (dec)
      DEC_DIR:        rd_w = dir_q;
      DEC_OUT:        rd_w = out_q;
      DEC_IN:         rd_w = sync_in;
      DEC_IRQ_EN:     rd_w = irq_en_q;
      DEC_IRQ_RISE:   rd_w = rise_q;
      DEC_IRQ_FALL:   rd_w = fall_q;
      DEC_IRQ_STATUS: rd_w = status_q;
      default:        rd_w = '0;
    endcase
    prdata = '0;
    if (psel && !pwrite) prdata[W-1:0] = rd_w;
  end

  assign pready        = 1'b1;
  assign pslverr       = psel & penable & (dec == DEC_NONE);
  assign n_gpio_pin_oe = ~dir_q;
  assign gpio_pin_out  = out_q;
  assign gpio_irq      = irq_q;
endmodule

// File: tb/tb_gpio_ctrl_v2.sv
// Directed bench for gpio_ctrl_v2: register table plus edge/W1C/reset sequences.
module tb_gpio_ctrl_v2;
  logic        pclk, n_p_reset;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [15:0] n_gpio_pin_oe, gpio_pin_out, gpio_pin_in;
  logic        gpio_irq;

  int nerr = 0;
  int nchk = 0;

  gpio_ctrl_v2 #(.GPIO_DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .pclk(pclk), .n_p_reset(n_p_reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .n_gpio_pin_oe(n_gpio_pin_oe), .gpio_pin_out(gpio_pin_out), .gpio_pin_in(gpio_pin_in),
    .gpio_irq(gpio_irq)
  );

  initial begin
    pclk = 0;
    forever #5 pclk = ~pclk;
  end

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    bit          err;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // All bus tasks enter and leave 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input bit experr, input string nm);
    psel = 1; pwrite = 1; penable = 0; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1;
    #1 chk({nm, "_slverr"}, 32'(pslverr), 32'(experr));
    @(posedge pclk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [31:0] exp, input bit experr, input string nm);
    psel = 1; pwrite = 0; penable = 0; paddr = a;
    @(posedge pclk); #1;
    penable = 1;
    #1;
    chk({nm, "_rdata"}, prdata, exp);
    chk({nm, "_slverr"}, 32'(pslverr), 32'(experr));
    @(posedge pclk); #1;
    psel = 0; penable = 0;
  endtask

  // Combinational read without a bus cycle; leaves psel high until the caller drops it.
  task automatic peek(input logic [7:0] a, output logic [31:0] d);
    psel = 1; pwrite = 0; penable = 0; paddr = a;
    #1 d = prdata;
  endtask

  logic [31:0] rd;

  initial begin
    tbl[0]  = '{1, 8'h00, 32'h0000_00F0, 32'h0, 0};
    tbl[1]  = '{1, 8'h04, 32'h0000_00A0, 32'h0, 0};
    tbl[2]  = '{1, 8'h1C, 32'h0000_0005, 32'h0, 0};
    tbl[3]  = '{1, 8'h20, 32'h0000_0080, 32'h0, 0};
    tbl[4]  = '{0, 8'h04, 32'h0, 32'h0000_0025, 0};
    tbl[5]  = '{0, 8'h00, 32'h0, 32'h0000_00F0, 0};
    tbl[6]  = '{0, 8'h1C, 32'h0, 32'h0, 0};
    tbl[7]  = '{0, 8'h20, 32'h0, 32'h0, 0};
    tbl[8]  = '{1, 8'h00, 32'hFFFF_00F0, 32'h0, 0};
    tbl[9]  = '{0, 8'h00, 32'h0, 32'h0000_00F0, 0};
    tbl[10] = '{1, 8'h08, 32'h0000_1234, 32'h0, 0};
    tbl[11] = '{0, 8'h08, 32'h0, 32'h0, 0};
    tbl[12] = '{1, 8'h24, 32'h0000_FFFF, 32'h0, 1};
    tbl[13] = '{0, 8'h24, 32'h0, 32'h0, 1};
    tbl[14] = '{0, 8'hFC, 32'h0, 32'h0, 1};
    tbl[15] = '{0, 8'h04, 32'h0, 32'h0000_0025, 0};
    tbl[16] = '{1, 8'h0C, 32'h0000_0001, 32'h0, 0};
    tbl[17] = '{1, 8'h10, 32'h0000_0001, 32'h0, 0};
    tbl[18] = '{0, 8'h0C, 32'h0, 32'h0000_0001, 0};
    tbl[19] = '{0, 8'h10, 32'h0, 32'h0000_0001, 0};
    tbl[20] = '{0, 8'h14, 32'h0, 32'h0, 0};
    tbl[21] = '{0, 8'h07, 32'h0, 32'h0000_0025, 0};

    // Reset with all pins held high.
    n_p_reset = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    gpio_pin_in = 16'hFFFF;
    #1;
    chk("rst_oe", 32'(n_gpio_pin_oe), 32'h0000_FFFF);
    chk("rst_out", 32'(gpio_pin_out), 32'h0);
    chk("rst_irq", 32'(gpio_irq), 32'h0);
    chk("rst_slverr", 32'(pslverr), 32'h0);
    chk("pready", 32'(pready), 32'h1);
    repeat (3) @(posedge pclk);
    #1 n_p_reset = 1;
    cyc(6);
    for (int a = 0; a <= 8; a++)
      apb_read(8'(a * 4), (a == 2) ? 32'h0000_FFFF : 32'h0, 0, $sformatf("rst_reg%0d", a));
    chk("rst_irq_after", 32'(gpio_irq), 32'h0);

    gpio_pin_in = 16'h0000;
    cyc(4);
    for (int i = 0; i < 22; i++) begin
      if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data, tbl[i].err, $sformatf("vec%0d", i));
      else           apb_read(tbl[i].addr, tbl[i].exp, tbl[i].err, $sformatf("vec%0d", i));
    end
    chk("pin_out", 32'(gpio_pin_out), 32'h0000_0025);
    chk("pin_oe", 32'(n_gpio_pin_oe), 32'h0000_FF0F);

    // Rising edge on pin 0: IN at edge 2, STATUS at edge 3, irq at edge 4.
    gpio_pin_in[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge pclk); #1;
      peek(8'h08, rd);
      chk($sformatf("rise_in_e%0d", k), rd, (k >= 2) ? 32'h1 : 32'h0);
      peek(8'h18, rd);
      chk($sformatf("rise_st_e%0d", k), rd, (k >= 3) ? 32'h1 : 32'h0);
      chk($sformatf("rise_irq_e%0d", k), 32'(gpio_irq), (k >= 4) ? 32'h1 : 32'h0);
      psel = 0;
    end
    apb_write(8'h18, 32'h1, 0, "w1c0");
    peek(8'h18, rd);
    psel = 0;
    chk("w1c0_status", rd, 32'h0);
    chk("w1c0_irq_hold", 32'(gpio_irq), 32'h1);
    cyc(1);
    chk("w1c0_irq_drop", 32'(gpio_irq), 32'h0);

    // Both edges on pin 1; a W1C commits on the same edge the fall event lands.
    apb_write(8'h10, 32'h2, 0, "rise1");
    apb_write(8'h14, 32'h2, 0, "fall1");
    cyc(1);
    gpio_pin_in[1] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge pclk); #1;
      if (c == 2 || c == 3 || c == 7) begin
        peek(8'h18, rd);
        psel = 0;
        chk($sformatf("both_st_c%0d", c), rd, (c >= 3) ? 32'h2 : 32'h0);
      end
      if (c == 5) gpio_pin_in[1] = 1'b0;
      if (c == 6) begin psel = 1; pwrite = 1; penable = 0; paddr = 8'h18; pwdata = 32'h2; end
      if (c == 7) begin psel = 1; pwrite = 1; paddr = 8'h18; pwdata = 32'h2; penable = 1; end
    end
    psel = 0; penable = 0; pwrite = 0;
    peek(8'h18, rd);
    psel = 0;
    chk("set_wins", rd, 32'h2);
    apb_write(8'h18, 32'h2, 0, "w1c1");
    peek(8'h18, rd);
    psel = 0;
    chk("w1c1_status", rd, 32'h0);

    // Build STATUS = 0x3, then reset in the middle of a write access phase.
    apb_write(8'h14, 32'h3, 0, "fall3");
    apb_write(8'h10, 32'h3, 0, "rise3");
    gpio_pin_in[0] = 1'b0;
    gpio_pin_in[1] = 1'b1;
    cyc(4);
    peek(8'h18, rd);
    psel = 0;
    chk("pre_rst_status", rd, 32'h3);
    cyc(1);
    chk("pre_rst_irq", 32'(gpio_irq), 32'h1);
    psel = 1; pwrite = 1; penable = 0; paddr = 8'h00; pwdata = 32'hFFFF;
    @(posedge pclk); #1;
    penable = 1;
    #2 n_p_reset = 0;
    gpio_pin_in = 16'hFFFF;
    #1;
    chk("mid_rst_oe", 32'(n_gpio_pin_oe), 32'h0000_FFFF);
    chk("mid_rst_out", 32'(gpio_pin_out), 32'h0);
    chk("mid_rst_irq", 32'(gpio_irq), 32'h0);
    psel = 0; penable = 0; pwrite = 0;
    repeat (2) @(posedge pclk);
    #1 n_p_reset = 1;
    // RISE is live while the synchroniser is still filling with ones.
    apb_write(8'h10, 32'hFFFF, 0, "rearm_rise");
    cyc(4);
    peek(8'h18, rd);
    chk("rearm_status", rd, 32'h0);
    peek(8'h08, rd);
    chk("rearm_in", rd, 32'h0000_FFFF);
    peek(8'h00, rd);
    psel = 0;
    chk("rearm_dir", rd, 32'h0);
    chk("rearm_irq", 32'(gpio_irq), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
